// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the copy engine: combinational ROM read port plus a
// single-port RAM with one-cycle read latency.
interface mem_copy_engine_if #(
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int NUM_ROM_ADDRESS = 256
);
  localparam int RAW = $clog2(NUM_RAM_ADDRESS);
  localparam int ROW = $clog2(NUM_ROM_ADDRESS);

  logic [ROW-1:0] rom_address;
  logic [31:0]    rom_data;
  logic [RAW-1:0] ram_address;
  logic           ram_enable;
  logic           ram_write;
  logic [31:0]    ram_wdata;
  logic [31:0]    ram_rdata;

  modport master (
    output rom_address,
    output ram_address,
    output ram_enable,
    output ram_write,
    output ram_wdata,
    input  rom_data,
    input  ram_rdata
  );

  modport slave (
    input  rom_address,
    input  ram_address,
    input  ram_enable,
    input  ram_write,
    input  ram_wdata,
    output rom_data,
    output ram_rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Copies a block of ROM words into RAM, optionally reading each word back and
// aborting on the first mismatch.
module mem_copy_engine #(
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int NUM_ROM_ADDRESS = 256,
  localparam int RAW = $clog2(NUM_RAM_ADDRESS),
  localparam int ROW = $clog2(NUM_ROM_ADDRESS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW-1:0]      src_base,
  input  logic [RAW-1:0]      dst_base,
  input  logic [ROW:0]        length,
  input  logic                verify_en,
  mem_copy_engine_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [RAW-1:0]      err_addr
);

  localparam logic [ROW-1:0] SRC_ONE  = ROW'(1);
  localparam logic [RAW-1:0] DST_ONE  = RAW'(1);
  localparam logic [ROW:0]   CNT_ONE  = (ROW+1)'(1);
  localparam logic [ROW-1:0] SRC_LAST = ROW'(NUM_ROM_ADDRESS - 1);
  localparam logic [RAW-1:0] DST_LAST = RAW'(NUM_RAM_ADDRESS - 1);

  typedef enum logic [2:0] {IDLE, READ, WRITE, VREAD, VCHECK, DONE} state_t;

  state_t         state_reg, state_next;
  logic [ROW-1:0] src_reg;
  logic [RAW-1:0] dst_reg;
  logic [ROW:0]   len_reg;
  logic [ROW:0]   count_reg;
  logic           verify_reg;
  logic [31:0]    data_reg;
  logic           error_reg;
  logic [RAW-1:0] err_addr_reg;

  logic           last_word;
  logic           mismatch;
  logic           step;

  assign last_word = (count_reg + CNT_ONE) == len_reg;
  assign mismatch  = mem.ram_rdata != data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // step marks the return to READ for the next word (addresses advance)
  always_comb begin
    state_next     = state_reg;
    mem.ram_enable = 1'b0;
    mem.ram_write  = 1'b0;
    step           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? DONE : READ;
        end
      end
      READ: state_next = WRITE;
      WRITE: begin
        mem.ram_enable = 1'b1;
        mem.ram_write  = 1'b1;
        if (verify_reg) begin
          state_next = VREAD;
        end else if (last_word) begin
          state_next = DONE;
        end else begin
          state_next = READ;
          step       = 1'b1;
        end
      end
      VREAD: begin
        mem.ram_enable = 1'b1;
        state_next     = VCHECK;
      end
      VCHECK: begin
        if (mismatch || last_word) begin
          state_next = DONE;
        end else begin
          state_next = READ;
          step       = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      verify_reg   <= 1'b0;
      data_reg     <= '0;
      error_reg    <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        error_reg <= 1'b0;
        if (length != '0) begin
          src_reg      <= src_base;
          dst_reg      <= dst_base;
          len_reg      <= length;
          count_reg    <= '0;
          verify_reg   <= verify_en;
          err_addr_reg <= '0;
        end
      end
      if (state_reg == READ) begin
        data_reg <= mem.rom_data;
      end
      if (state_reg == VCHECK && mismatch) begin
        error_reg    <= 1'b1;
        err_addr_reg <= dst_reg;
      end
      // Non-power-of-two depths still wrap to address 0
      if (step) begin
        src_reg   <= (src_reg == SRC_LAST) ? '0 : src_reg + SRC_ONE;
        dst_reg   <= (dst_reg == DST_LAST) ? '0 : dst_reg + DST_ONE;
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign mem.rom_address = src_reg;
  assign mem.ram_address = dst_reg;
  assign mem.ram_wdata   = data_reg;
  assign busy            = state_reg != IDLE;
  assign done            = state_reg == DONE;
  assign error           = error_reg;
  assign err_addr        = err_addr_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: ROM/RAM models plus a word-level reference model
// of each copy (expected RAM image, strobe order, done cycle, error state).
module tb_mem_copy_engine;
  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_base;
  logic [7:0] dst_base;
  logic [8:0] length;
  logic       verify_en;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] err_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_copy_engine_if #(.NUM_RAM_ADDRESS(N), .NUM_ROM_ADDRESS(N)) mem ();

  mem_copy_engine #(.NUM_RAM_ADDRESS(N), .NUM_ROM_ADDRESS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .length    (length),
    .verify_en (verify_en),
    .mem       (mem),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_addr  (err_addr)
  );

  logic [31:0] rom_mem [N];
  logic [31:0] ram_mem [N];
  logic [31:0] exp_ram [N];
  int          wr_count;
  int          rd_count;
  logic [7:0]  wr_log [$];
  bit          kind_log [$];
  bit          corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = 8'h00;

  assign mem.rom_data = rom_mem[mem.rom_address];

  // RAM model: write on strobe, registered read data, optional read corruption
  always @(posedge clk) begin
    if (mem.ram_enable) begin
      if (mem.ram_write) begin
        ram_mem[mem.ram_address] = mem.ram_wdata;
        wr_count = wr_count + 1;
        wr_log.push_back(mem.ram_address);
        kind_log.push_back(1'b1);
      end else begin
        mem.ram_rdata <= (corrupt_en && mem.ram_address == corrupt_addr)
                         ? (ram_mem[mem.ram_address] ^ 32'h0000_0100)
                         : ram_mem[mem.ram_address];
        rd_count = rd_count + 1;
        kind_log.push_back(1'b0);
      end
    end
  end

  task automatic clear_logs();
    wr_count = 0;
    rd_count = 0;
    wr_log.delete();
    kind_log.delete();
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] len, input bit ver, input string name);
    int         exp_cycle;
    bit         exp_err;
    logic [7:0] exp_ea;
    logic [7:0] exp_wr [$];
    bit         exp_kind [$];
    int         words;
    int         got_cycle;
    bit         busy_ok;
    int         bad_words;
    bit         seq_ok;
    logic [7:0] ra;
    logic [7:0] sa;

    for (int i = 0; i < N; i++) exp_ram[i] = ram_mem[i];
    exp_err = 1'b0;
    exp_ea  = 8'h00;
    words   = 0;
    for (int i = 0; i < int'(len); i++) begin
      ra = 8'((int'(d) + i) % N);
      sa = 8'((int'(s) + i) % N);
      exp_ram[ra] = rom_mem[sa];
      exp_wr.push_back(ra);
      exp_kind.push_back(1'b1);
      words++;
      if (ver) begin
        exp_kind.push_back(1'b0);
        if (corrupt_en && ra == corrupt_addr) begin
          exp_err = 1'b1;
          exp_ea  = ra;
          break;
        end
      end
    end
    exp_cycle = 1 + words * (ver ? 4 : 2);

    @(negedge clk);
    clear_logs();
    src_base  = s;
    dst_base  = d;
    length    = len;
    verify_en = ver;
    start     = 1'b1;
    got_cycle = -1;
    busy_ok   = 1'b1;
    for (int c = 1; c <= 5000 && got_cycle < 0; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got_cycle = c;
        start = 1'b0;
      end else begin
        start     = 1'($urandom_range(0, 1));
        src_base  = 8'($urandom);
        dst_base  = 8'($urandom);
        length    = 9'($urandom_range(0, N));
        verify_en = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;

    checks++;
    if (got_cycle !== exp_cycle) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, got_cycle, exp_cycle);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s busy_during_copy: got busy low expected high", name);
    end
    checks++;
    if (error !== exp_err) begin
      failures++;
      $display("FAIL %s error: got %b expected %b", name, error, exp_err);
    end
    checks++;
    if (err_addr !== exp_ea) begin
      failures++;
      $display("FAIL %s err_addr: got %h expected %h", name, err_addr, exp_ea);
    end
    bad_words = 0;
    for (int i = 0; i < N; i++) if (ram_mem[i] !== exp_ram[i]) bad_words++;
    checks++;
    if (bad_words != 0) begin
      failures++;
      $display("FAIL %s ram_image: got %0d wrong words expected 0", name, bad_words);
    end
    seq_ok = (wr_log.size() == exp_wr.size()) && (kind_log.size() == exp_kind.size());
    if (seq_ok) begin
      foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) seq_ok = 1'b0;
      foreach (exp_kind[i]) if (kind_log[i] !== exp_kind[i]) seq_ok = 1'b0;
    end
    checks++;
    if (!seq_ok) begin
      failures++;
      $display("FAIL %s strobe_seq: got %0d writes/%0d strobes expected %0d writes/%0d strobes",
               name, wr_log.size(), kind_log.size(), exp_wr.size(), exp_kind.size());
    end

    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== exp_err) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b error=%b expected 0 0 %b",
               name, done, busy, error, exp_err);
    end
    $display("copy %s src=%h dst=%h len=%0d verify=%0b done_cycle=%0d error=%b err_addr=%h",
             name, s, d, len, ver, got_cycle, error, err_addr);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b1;
    src_base  = 8'h55;
    dst_base  = 8'hAA;
    length    = 9'd7;
    verify_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, err_addr, mem.ram_enable, mem.ram_write} !== 13'b0 ||
        mem.ram_address !== 8'h00 || mem.rom_address !== 8'h00 || mem.ram_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b error=%b err_addr=%h en=%b wr=%b ra=%h ro=%h wd=%h expected all 0",
               busy, done, error, err_addr, mem.ram_enable, mem.ram_write,
               mem.ram_address, mem.rom_address, mem.ram_wdata);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
    $display("reset busy=%b done=%b error=%b", busy, done, error);
  endtask

  task automatic test_copy_basic();
    rom_mem[8'h10] = 32'hAAAA_000A;
    rom_mem[8'h11] = 32'hBBBB_000B;
    rom_mem[8'h12] = 32'hCCCC_000C;
    rom_mem[8'h13] = 32'hDDDD_000D;
    run_copy(8'h10, 8'h20, 9'd4, 1'b0, "basic");
    checks++;
    if (ram_mem[8'h23] !== 32'hDDDD_000D) begin
      failures++;
      $display("FAIL basic_last_word: got %h expected DDDD000D", ram_mem[8'h23]);
    end
  endtask

  task automatic test_verify_pass();
    run_copy(8'h10, 8'h20, 9'd4, 1'b1, "verify_pass");
  endtask

  task automatic test_verify_fail();
    corrupt_en   = 1'b1;
    corrupt_addr = 8'h21;
    run_copy(8'h30, 8'h20, 9'd3, 1'b1, "verify_fail");
    corrupt_en   = 1'b0;
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || err_addr !== 8'h21) begin
      failures++;
      $display("FAIL verify_fail_sticky: got error=%b err_addr=%h expected 1 21", error, err_addr);
    end
  endtask

  task automatic test_wrap();
    run_copy(8'hFE, 8'hFF, 9'd3, 1'b0, "wrap");
  endtask

  task automatic test_length_zero();
    @(negedge clk);
    clear_logs();
    start     = 1'b1;
    length    = 9'd0;
    verify_en = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL len0_cycle1: got done=%b busy=%b error=%b expected 1 1 0", done, busy, error);
    end
    length = 9'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_cycle2: got done=%b busy=%b expected 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_count + rd_count != 0) begin
      failures++;
      $display("FAIL len0_ignored_start: got busy=%b strobes=%0d expected 0 0", busy, wr_count + rd_count);
    end
    $display("len0 strobes=%0d busy=%b", wr_count + rd_count, busy);
  endtask

  task automatic test_reset_mid();
    logic [7:0]  s;
    logic [7:0]  d;
    logic [31:0] third_before;
    int          writes_at_reset;
    bit          saw_done;
    s = 8'h40;
    d = 8'h80;
    third_before = ram_mem[8'h82];
    @(negedge clk);
    clear_logs();
    src_base  = s;
    dst_base  = d;
    length    = 9'd4;
    verify_en = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, error, err_addr, mem.ram_enable, mem.ram_write} !== 13'b0 ||
        mem.ram_address !== 8'h00 || mem.rom_address !== 8'h00 || mem.ram_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b en=%b ra=%h ro=%h wd=%h expected all 0",
               busy, done, mem.ram_enable, mem.ram_address, mem.rom_address, mem.ram_wdata);
    end
    writes_at_reset = wr_count;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || wr_count != writes_at_reset || rd_count != 0 || writes_at_reset > 2) begin
      failures++;
      $display("FAIL reset_mid_abort: got activity=%b writes=%0d->%0d reads=%0d expected no activity, <=2 writes",
               saw_done, writes_at_reset, wr_count, rd_count);
    end
    checks++;
    if (ram_mem[d] !== rom_mem[s] || ram_mem[8'h82] !== third_before) begin
      failures++;
      $display("FAIL reset_mid_ram: got first=%h third=%h expected %h %h",
               ram_mem[d], ram_mem[8'h82], rom_mem[s], third_before);
    end
    $display("reset_mid writes=%0d", wr_count);
    run_copy(8'h40, 8'h80, 9'd4, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [7:0] d;
    logic [8:0] len;
    bit         ver;
    for (int k = 0; k < 8; k++) begin
      s   = 8'($urandom);
      d   = 8'($urandom);
      len = 9'($urandom_range(1, 24));
      ver = 1'($urandom_range(0, 1));
      corrupt_en   = ver && ($urandom_range(0, 1) == 1);
      corrupt_addr = 8'((int'(d) + int'($urandom_range(0, int'(len) - 1))) % N);
      run_copy(s, d, len, ver, "random");
      corrupt_en = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    src_base  = 8'h00;
    dst_base  = 8'h00;
    length    = 9'd0;
    verify_en = 1'b0;
    wr_count  = 0;
    rd_count  = 0;
    for (int i = 0; i < N; i++) begin
      rom_mem[i] = {8'(i), 24'($urandom)};
      ram_mem[i] = $urandom;
    end
    test_reset();
    test_copy_basic();
    test_verify_pass();
    test_verify_fail();
    test_length_zero();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter NUM_RAM_ADDRESS, default 256, RAM depth in 32-bit words; RAW = $clog2(NUM_RAM_ADDRESS).
REQ-002 SHALL have parameter NUM_ROM_ADDRESS, default 256, ROM depth in 32-bit words; ROW = $clog2(NUM_ROM_ADDRESS).
REQ-003 SHALL use one clock and a synchronous active-high reset; ports clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  one-cycle copy request, sampled only in IDLE.
REQ-007 src_base  input  ROW  first ROM word address.
REQ-008 dst_base  input  RAW  first RAM word address.
REQ-009 length  input  ROW+1  word count, 0..NUM_ROM_ADDRESS.
REQ-010 verify_en  input  1  enables read-back compare of each written word.
REQ-011 rom_address  output  ROW  ROM read address.
REQ-012 rom_data  input  32  ROM word; combinational, valid the same cycle as rom_address.
REQ-013 ram_address  output  RAW  RAM word address.
REQ-014 ram_enable  output  1  RAM access strobe.
REQ-015 ram_write  output  1  1 = write, 0 = read; meaningful only with ram_enable.
REQ-016 ram_wdata  output  32  RAM write data.
REQ-017 ram_rdata  input  32  RAM read data; valid one cycle after a read strobe.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 done  output  1  one-cycle pulse at end of copy.
REQ-020 error  output  1  verify mismatch flag; sticky until the next accepted start.
REQ-021 err_addr  output  RAW  RAM address of the first mismatch.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WRITE, VREAD, VCHECK, DONE.
REQ-023 IDLE: start=1 with length>0 -> latch src_base, dst_base, length, verify_en; clear error and err_addr; go to READ.
REQ-024 IDLE: start=1 with length=0 -> clear error; go directly to DONE; no RAM access.
REQ-025 READ: rom_address = current source address; capture rom_data into the data register; go to WRITE.
REQ-026 WRITE: ram_enable=1, ram_write=1, ram_address = current destination, ram_wdata = data register; go to VREAD if verify latched, else advance.
REQ-027 VREAD: ram_enable=1, ram_write=0, same ram_address; go to VCHECK.
REQ-028 VCHECK: compare ram_rdata to data register; on mismatch set error, load err_addr, and go to DONE (abort); on match, advance.
REQ-029 Advance: if the word count equals length, go to DONE; otherwise increment both addresses and go to READ.
REQ-030 Addresses SHALL wrap modulo NUM_ROM_ADDRESS and NUM_RAM_ADDRESS independently; there is no bounds error.
REQ-031 DONE: done=1 for exactly one cycle; next state is IDLE.
REQ-032 ram_enable and ram_write SHALL be 0 in IDLE, READ, VCHECK and DONE.
REQ-033 start while busy SHALL be ignored, with no effect on the current copy.
REQ-034 Throughput: 2 cycles/word without verify, 4 with; start in cycle 0 -> done in cycle 2L+1 (no verify) or 4L+1 (verify).
REQ-035 Input changes on src_base/dst_base/length/verify_en during a copy SHALL have no effect.

Reset
REQ-036 reset SHALL force IDLE on the next edge and override all other inputs in the same cycle.
REQ-037 After reset: busy=0, done=0, error=0, err_addr=0, ram_enable=0, ram_write=0, ram_address=0, rom_address=0, ram_wdata=0.
REQ-038 Reset mid-copy SHALL abort with no further RAM strobes and no done pulse; already-written words are left as-is.

Verification
REQ-039 Copy, no verify: src=0x10, dst=0x20, length=4, ROM[0x10..0x13]=A..D -> RAM[0x20..0x23]=A..D; 4 write strobes; done in cycle 9; error=0.
REQ-040 Verify pass: same as REQ-039 with verify_en=1 -> 8 RAM strobes alternating write/read; done in cycle 17; error=0.
REQ-041 Verify fail: length=3, RAM model corrupts read-back at 0x21 -> error=1, err_addr=0x21; done after the 2nd word's VCHECK; no write to 0x22.
REQ-042 Wrap: src=0xFE, dst=0xFF, length=3 -> writes to RAM 0xFF, 0x00, 0x01 with ROM 0xFE, 0xFF, 0x00.
REQ-043 length=0 -> done in cycle 1, busy high for 1 cycle, zero RAM strobes; start during busy ignored.
REQ-044 Reset asserted in a WRITE cycle of word 2 -> next cycle IDLE with all outputs zero, no done pulse; next start runs normally.
